// File: rtl/clken_pkg.sv
// Shared types and standard increments for the clock-enable NCO bank.
// Increments assume a 32-bit accumulator: enable rate = f_refclk * inc / 2^32.
package clken_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [31:0] INC_OFF  = 32'h0000_0000;
  localparam logic [31:0] INC_DIV2 = 32'h8000_0000;
  localparam logic [31:0] INC_DIV3 = 32'h5555_5556;
  localparam logic [31:0] INC_DIV4 = 32'h4000_0000;

endpackage

// File: rtl/clken_nco_ch.sv
// One phase-accumulator channel: a carry-out gives a one-cycle enable pulse,
// and the registered accumulator MSB gives a square wave.
module clken_nco_ch #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  input  logic [ACC_W-1:0] inc,
  input  logic [ACC_W-1:0] phase,
  output logic             ce,
  output logic             sq
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] inc_q;
  logic [ACC_W:0]   sum;

  // Extra top bit captures the wrap, which is the enable pulse.
  always_comb sum = {1'b0, acc_q} + {1'b0, inc_q};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement or process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      inc_q <= '0;
      ce    <= 1'b0;
      sq    <= 1'b0;
    end else if (load) begin
      acc_q <= phase;
      inc_q <= inc;
      ce    <= 1'b0;
      sq    <= phase[ACC_W-1];
    end else if (run) begin
      acc_q <= sum[ACC_W-1:0];
      ce    <= sum[ACC_W];
      sq    <= sum[ACC_W-1];
    end else begin
      ce    <= 1'b0;
    end
  end

endmodule

// File: rtl/clken_nco_bank.sv
// Bank of NUM_CH fractional clock-enable NCOs with a coherent reload strobe
// and a lock indicator that rises LOCK_CYCLES edges after the last reload.
module clken_nco_bank
  import clken_pkg::*;
#(
  parameter int NUM_CH      = 5,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                    refclk,
  input  logic                    rst_n,
  input  logic [NUM_CH*ACC_W-1:0] cfg_inc,
  input  logic [NUM_CH*ACC_W-1:0] cfg_phase,
  input  logic                    cfg_load,
  input  logic [NUM_CH-1:0]       ch_en,
  output logic [NUM_CH-1:0]       ce_out,
  output logic [NUM_CH-1:0]       sq_out,
  output logic                    locked
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             running;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      locked  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      locked  <= (state_d == LOCKED);
    end
  end

  // NOTE: next-state outputs get defaults first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cfg_load) begin
      state_d = SETTLE;
      cnt_d   = '0;
    end else if (state_q == SETTLE) begin
      if (cnt_q == CNT_LAST) state_d = LOCKED;
      else                   cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  // Accumulators stay parked at their reset value until the first reload.
  assign running = (state_q != IDLE);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clken_nco_ch #(
      .ACC_W (ACC_W)
    ) u_ch (
      .clk   (refclk),
      .rst_n (rst_n),
      .load  (cfg_load),
      .run   (running & ch_en[i]),
      .inc   (cfg_inc[i*ACC_W +: ACC_W]),
      .phase (cfg_phase[i*ACC_W +: ACC_W]),
      .ce    (ce_out[i]),
      .sq    (sq_out[i])
    );
  end

endmodule

// File: tb/tb_clken_nco_bank.sv
// Self-checking bench for clken_nco_bank: a per-cycle reference model feeds a
// scoreboard queue, plus directed checks on pulse timing, counts and lock.
module tb_clken_nco_bank;
  import clken_pkg::*;

  localparam int NUM_CH = 5;
  localparam int ACC_W  = 32;
  localparam int LOCK   = 16;

  typedef struct packed {
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] sq;
    logic              locked;
  } exp_t;

  logic                    refclk;
  logic                    rst_n;
  logic [NUM_CH*ACC_W-1:0] cfg_inc;
  logic [NUM_CH*ACC_W-1:0] cfg_phase;
  logic                    cfg_load;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH-1:0]       ce_out;
  logic [NUM_CH-1:0]       sq_out;
  logic                    locked;

  int total = 0;
  int bad   = 0;

  exp_t sb[$];

  state_e           m_state;
  int               m_cnt;
  logic [ACC_W-1:0] m_acc [NUM_CH];
  logic [ACC_W-1:0] m_inc [NUM_CH];
  logic [NUM_CH-1:0] m_ce, m_sq;
  logic             m_locked;

  clken_nco_bank #(
    .NUM_CH      (NUM_CH),
    .ACC_W       (ACC_W),
    .LOCK_CYCLES (LOCK)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .cfg_inc   (cfg_inc),
    .cfg_phase (cfg_phase),
    .cfg_load  (cfg_load),
    .ch_en     (ch_en),
    .ce_out    (ce_out),
    .sq_out    (sq_out),
    .locked    (locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic model_reset();
    m_state  = IDLE;
    m_cnt    = 0;
    m_ce     = '0;
    m_sq     = '0;
    m_locked = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_acc[i] = '0;
      m_inc[i] = '0;
    end
  endtask

  // Advances the model across the coming rising edge using the current inputs.
  task automatic model_update();
    state_e         ns;
    int             nc;
    logic [ACC_W:0] s;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ns = m_state;
    nc = m_cnt;
    if (cfg_load) begin
      ns = SETTLE;
      nc = 0;
    end else if (m_state == SETTLE) begin
      if (m_cnt == LOCK - 1) ns = LOCKED;
      else                   nc = m_cnt + 1;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_load) begin
        m_inc[i] = cfg_inc[i*ACC_W +: ACC_W];
        m_acc[i] = cfg_phase[i*ACC_W +: ACC_W];
        m_ce[i]  = 1'b0;
        m_sq[i]  = m_acc[i][ACC_W-1];
      end else if (m_state != IDLE && ch_en[i]) begin
        s        = {1'b0, m_acc[i]} + {1'b0, m_inc[i]};
        m_acc[i] = s[ACC_W-1:0];
        m_ce[i]  = s[ACC_W];
        m_sq[i]  = s[ACC_W-1];
      end else begin
        m_ce[i]  = 1'b0;
      end
    end
    m_state  = ns;
    m_cnt    = nc;
    m_locked = (ns == LOCKED);
  endtask

  // One clock: push the model's prediction, let the edge happen, pop and compare.
  task automatic step();
    exp_t e;
    model_update();
    e.ce     = m_ce;
    e.sq     = m_sq;
    e.locked = m_locked;
    sb.push_back(e);
    @(posedge refclk);
    #1;
    e = sb.pop_front();
    total++;
    if (ce_out !== e.ce) begin
      bad++;
      $display("FAIL sb_ce at %0t: got %b want %b", $time, ce_out, e.ce);
    end
    total++;
    if (sq_out !== e.sq) begin
      bad++;
      $display("FAIL sb_sq at %0t: got %b want %b", $time, sq_out, e.sq);
    end
    total++;
    if (locked !== e.locked) begin
      bad++;
      $display("FAIL sb_locked at %0t: got %b want %b", $time, locked, e.locked);
    end
  endtask

  task automatic set_ch(input int ch, input logic [ACC_W-1:0] inc, input logic [ACC_W-1:0] ph);
    cfg_inc[ch*ACC_W +: ACC_W]   = inc;
    cfg_phase[ch*ACC_W +: ACC_W] = ph;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    cfg_load  = 1'b0;
    ch_en     = '1;
    cfg_inc   = {NUM_CH{INC_DIV4}};
    cfg_phase = {NUM_CH{32'hC000_0000}};
    model_reset();
    repeat (3) @(posedge refclk);
    #1;
    total++;
    if ({ce_out, sq_out, locked} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ce=%b sq=%b locked=%b want all zero", ce_out, sq_out, locked);
    end
    rst_n = 1'b1;
    // Config present and channels enabled, but no load: nothing may move.
    for (int n = 0; n < 100; n++) step();
  endtask

  task automatic test_load_run();
    int first0 = -1, first1 = -1, lock_edge = -1;
    int last1 = -100, lead_err = 0;
    int cnt2 = 0, last2 = -1, gap_err = 0;
    int cnt3 = 0, sq3_err = 0, cnt4 = 0;
    set_ch(0, INC_DIV4, 32'h0000_0000);
    set_ch(1, INC_DIV4, 32'hC000_0000);
    set_ch(2, INC_DIV3, 32'h0000_0000);
    set_ch(3, INC_OFF,  32'h8000_0000);
    set_ch(4, 32'h8000_0001, 32'h0000_0000);
    ch_en    = '1;
    cfg_load = 1'b1;
    step();
    cfg_load  = 1'b0;
    // Changing the config ports after the load must have no effect.
    cfg_inc   = {$urandom, $urandom, $urandom, $urandom, $urandom};
    cfg_phase = {$urandom, $urandom, $urandom, $urandom, $urandom};
    for (int n = 1; n <= 3000; n++) begin
      step();
      if (ce_out[0] && first0 < 0) first0 = n;
      if (ce_out[1] && first1 < 0) first1 = n;
      if (locked && lock_edge < 0) lock_edge = n;
      if (ce_out[1]) last1 = n;
      if (ce_out[0] && (n - last1) != 3) lead_err++;
      if (ce_out[2]) begin
        if (last2 >= 0 && (n - last2) != 3) gap_err++;
        last2 = n;
        cnt2++;
      end
      if (ce_out[3]) cnt3++;
      if (sq_out[3] !== 1'b1) sq3_err++;
      if (ce_out[4]) cnt4++;
    end
    total++;
    if (first0 != 4) begin
      bad++; $display("FAIL ch0_first_pulse: got edge %0d want 4", first0);
    end
    total++;
    if (first1 != 1) begin
      bad++; $display("FAIL ch1_first_pulse: got edge %0d want 1", first1);
    end
    total++;
    if (lead_err != 0) begin
      bad++; $display("FAIL ch1_lead: %0d ch0 pulses not 3 cycles after ch1, want 0", lead_err);
    end
    total++;
    if (lock_edge != LOCK) begin
      bad++; $display("FAIL lock_time: got edge %0d want %0d", lock_edge, LOCK);
    end
    total++;
    if (cnt2 != 1000) begin
      bad++; $display("FAIL div3_count: got %0d want 1000", cnt2);
    end
    total++;
    if (gap_err != 0) begin
      bad++; $display("FAIL div3_gap: %0d gaps not 3 cycles, want 0", gap_err);
    end
    total++;
    if (cnt3 != 0 || sq3_err != 0) begin
      bad++; $display("FAIL inc_zero: got %0d pulses %0d sq changes want 0 0", cnt3, sq3_err);
    end
    total++;
    if (cnt4 != 1500) begin
      bad++; $display("FAIL big_inc_count: got %0d want 1500", cnt4);
    end
  endtask

  task automatic test_pause();
    int p = -1, resume = -1, paused_pulses = 0;
    for (int n = 1; n <= 8 && p < 0; n++) begin
      step();
      if (ce_out[0]) p = n;
    end
    total++;
    if (p < 0) begin
      bad++; $display("FAIL pause_find_pulse: got none within 8 cycles want one");
      return;
    end
    ch_en[0] = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (ce_out[0]) paused_pulses++;
    end
    ch_en[0] = 1'b1;
    for (int n = 11; n <= 20 && resume < 0; n++) begin
      step();
      if (ce_out[0]) resume = n;
    end
    total++;
    if (paused_pulses != 0) begin
      bad++; $display("FAIL pause_silent: got %0d pulses want 0", paused_pulses);
    end
    total++;
    if (resume != 14) begin
      bad++; $display("FAIL pause_resume: got pulse %0d cycles after last want 14", resume);
    end
  endtask

  task automatic test_reload_reset();
    cfg_inc   = {NUM_CH{INC_DIV4}};
    cfg_phase = '0;
    set_ch(0, INC_DIV3, 32'h0000_1234);
    set_ch(3, INC_OFF,  32'h8000_0000);
    total++;
    if (locked !== 1'b1) begin
      bad++; $display("FAIL pre_reload_locked: got %b want 1", locked);
    end
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    total++;
    if (locked !== 1'b0) begin
      bad++; $display("FAIL reload_drops_lock: got %b want 0", locked);
    end
    repeat (5) step();
    total++;
    if (sq_out[3] !== 1'b1) begin
      bad++; $display("FAIL reload_sq3: got %b want 1", sq_out[3]);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({ce_out, sq_out, locked} !== '0) begin
      bad++;
      $display("FAIL async_reset: got ce=%b sq=%b locked=%b want all zero", ce_out, sq_out, locked);
    end
    cfg_load = 1'b1;
    @(posedge refclk);
    #1;
    cfg_load = 1'b0;
    total++;
    if ({ce_out, sq_out, locked} !== '0) begin
      bad++;
      $display("FAIL load_in_reset: got ce=%b sq=%b locked=%b want all zero", ce_out, sq_out, locked);
    end
    rst_n = 1'b1;
    // Back in IDLE: nothing runs or locks without a fresh load.
    repeat (20) step();
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_pause();
    test_reload_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clken_nco_bank.md
Name: clken_nco_bank

Overview:
- Parametrised bank of NUM_CH fractional clock-enable generators (phase-accumulator NCOs) running from one fast system clock.
- Produces per-channel single-cycle enable pulses and 50%-ish square waves with programmable ratio and phase.
- Lets core logic derive CPU, PPU and audio rates without extra PLL outputs.
- Has a configuration-load handshake and a settle/lock indicator.

Parameters:
- NUM_CH, 5, number of independent channels.
- ACC_W, 32, accumulator width; enable rate = f_refclk * inc / 2^ACC_W.
- LOCK_CYCLES, 16, settle cycles after cfg_load before locked asserts (>=1).

Ports:
- refclk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_inc  in  NUM_CH*ACC_W  per-channel phase increment; channel i uses bits [i*ACC_W +: ACC_W].
- cfg_phase  in  NUM_CH*ACC_W  per-channel accumulator start value, packed the same way.
- cfg_load  in  1  single-cycle strobe; captures cfg_inc into shadow registers and restarts all accumulators coherently.
- ch_en  in  NUM_CH  per-channel run enable.
- ce_out  out  NUM_CH  one-cycle pulse on accumulator carry-out.
- sq_out  out  NUM_CH  registered accumulator MSB (square wave).
- locked  out  1  configuration settled.

Behaviour:
- Reset (async, rst_n=0):
  - shadow inc = 0, acc = 0, ce_out = 0, sq_out = 0, locked = 0.
  - State = IDLE, settle counter = 0.
- States:
  - IDLE: accumulators held at 0.
  - SETTLE: accumulators run; counter increments each edge.
  - LOCKED: accumulators run; locked = 1.
- Transitions:
  - Any state with cfg_load=1 -> SETTLE, counter = 0.
  - SETTLE with counter == LOCK_CYCLES-1 -> LOCKED.
  - Otherwise hold.
  - If cfg_load is sampled at edge k, locked is high after edge k+LOCK_CYCLES.
  - A cfg_load during LOCKED drops locked at the next edge.
- Load edge:
  - shadow_inc[i] <= cfg_inc[i] and acc[i] <= cfg_phase[i] for every channel, regardless of ch_en.
  - ce_out <= 0; sq_out[i] <= cfg_phase[i][ACC_W-1].
- Run edge (state SETTLE/LOCKED, no cfg_load, ch_en[i]=1):
  - {carry, sum} = acc[i] + shadow_inc[i], computed at ACC_W+1 bits unsigned.
  - acc[i] <= sum; ce_out[i] <= carry; sq_out[i] <= sum[ACC_W-1].
  - Latency: the ce pulse appears in the cycle following the carry-producing edge.
- Channel paused (ch_en[i]=0): acc[i] and sq_out[i] hold; ce_out[i] <= 0. Resuming continues from the held phase.
- inc = 0: channel never pulses; sq_out is constant.
- inc >= 2^(ACC_W-1): pulse rate is still exact. sq_out is not meaningful as a clock (documented, not checked).
- Wrap: modulo-2^ACC_W arithmetic. Long-term pulse count over N cycles = floor((phase + N*inc) / 2^ACC_W), with no drift.
- Configuration ports are only sampled on cfg_load; changes at other times have no effect.
- Reset mid-operation: immediate return to reset values. cfg_load asserted while rst_n=0 is ignored.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Shared package clken_pkg:
  - State enum {IDLE, SETTLE, LOCKED}.
  - Named increment constants for the standard rates, e.g. INC_DIV4 = 32'h4000_0000 and INC_DIV3 = 32'h5555_5556.
- One sub-module clken_nco_ch:
  - Contains a single accumulator, shadow increment, ce and sq registers.
  - Inputs: load, run, inc, phase.
  - Instantiated NUM_CH times in a generate loop.
- Top level owns the state machine, settle counter and locked.

Test Plan:
- Reset then no cfg_load for 100 cycles -> ce_out=0, sq_out=0, locked=0 throughout.
- cfg_load with ch0 inc=32'h4000_0000, phase=0, ch_en=all ones -> ce_out[0] pulses after edges k+4, k+8, …; locked rises exactly after edge k+16.
- Same load with ch1 phase=32'hC000_0000, same inc -> first ce_out[1] after edge k+1, then every 4 cycles, always 3 cycles ahead of ch0.
- ch2 inc=32'h5555_5556, phase=0, run 3000 cycles after load -> exactly 1000 ce_out[2] pulses, with gaps of only 3 cycles.
- Deassert ch_en[0] for 10 cycles mid-run -> no ce_out[0] and acc held; after re-enable, pulse spacing resumes with the period offset by exactly 10 cycles.
- cfg_load during LOCKED with a new inc, then rst_n pulsed low mid-SETTLE -> locked falls on the load edge; on reset all outputs clear asynchronously and state returns to IDLE.
